// File: rtl/codeword_deserializer_pkg.sv
// Shared constants and types for the codeword deserializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package codeword_deserializer_pkg;

  // Default codeword width handed to the downstream decoder.
  localparam int CODE_W_DEF = 7;

  // Bit counter width for the default codeword width.
  localparam int CNT_W_DEF = $clog2(CODE_W_DEF);

  // Collection / presentation state.
  //   ST_IDLE  : no frame in progress, nothing presented
  //   ST_SHIFT : collecting bits of a frame, nothing presented
  //   ST_HOLD  : a word is presented on code; collection of a following
  //              frame may still be running underneath
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Counter width for an arbitrary codeword width; a one-bit word still
  // gets a one-bit counter so the declaration never collapses to zero width.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/codeword_deserializer_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pad input.
// Latency: STAGES clock cycles from pad to q.
// Backpressure: none; free-running sampler.
//
// Ports:
//   clock   - destination clock
//   reset_n - asynchronous active-low reset, forces every stage to 0
//   d       - asynchronous pad input
//   q       - synchronized output
module pin_sync #(
  parameter int STAGES = 2  // legal range 2..4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/codeword_deserializer.sv
// Collects LSB-first serial pad bits into CODE_W-bit words for the decoder.
// Latency: SYNC_STAGES+1 clock cycles from the final pad ser_clk edge to code_valid.
// Backpressure: valid/ready on code; a word completing while one is still held is dropped and flagged in overrun.
//
// Ports:
//   clock, reset_n                 - system clock, asynchronous active-low reset
//   ser_clk, ser_data, ser_frame   - asynchronous pad inputs (bit clock, data, frame enable)
//   code, code_valid, code_ready   - presented word and its handshake
//   overrun, clr_ovr               - sticky dropped-word flag and its synchronous clear
module codeword_deserializer
  import codeword_deserializer_pkg::*;
#(
  parameter int CODE_W      = CODE_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ser_clk,
  input  logic              ser_data,
  input  logic              ser_frame,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              overrun,
  input  logic              clr_ovr
);

  localparam int                CNT_W    = cnt_width(CODE_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(CODE_W - 1);

  // ---------------------------------------------------------------------------
  // Pad synchronization
  // ---------------------------------------------------------------------------
  logic clk_s;
  logic data_s;
  logic frame_s;

  pin_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (ser_clk),
    .q       (clk_s)
  );

  pin_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (ser_data),
    .q       (data_s)
  );

  pin_sync #(.STAGES(SYNC_STAGES)) u_sync_frame (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (ser_frame),
    .q       (frame_s)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state;
  state_e            state_nxt;
  logic              clk_prev;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CODE_W-1:0] shreg;

  logic              bit_evt;
  logic              in_frame;
  logic              word_done;
  logic              word_drop;
  logic [CODE_W:0]   shift_cat;
  logic [CODE_W-1:0] shift_nxt;

  // clk_prev resets to 0 together with the synchronizer, so the first
  // post-reset sample (also 0) can never look like a rising edge.
  assign bit_evt = clk_s & ~clk_prev;

  // Bits are only collected once the FSM has left IDLE; the cycle spent in
  // IDLE seeing frame_s high is the cycle that clears the shifter.
  assign in_frame = (state != ST_IDLE) & frame_s;

  // New bit enters at the top and the word moves toward bit 0, so after
  // CODE_W events the first bit received sits in code[0].
  assign shift_cat = {data_s, shreg};
  assign shift_nxt = shift_cat[CODE_W:1];

  assign word_done = in_frame & bit_evt & (bit_cnt == LAST_BIT);

  // A held word that is not leaving this cycle blocks the new one.
  assign word_drop = word_done & code_valid & ~code_ready;

  assign code_valid = (state == ST_HOLD);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (frame_s) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (word_done)     state_nxt = ST_HOLD;
        else if (!frame_s) state_nxt = ST_IDLE;
      end
      ST_HOLD: begin
        // A completing word keeps HOLD whether it replaces the transferred
        // word or is dropped; otherwise a transfer returns to collecting
        // (if a frame is still open) or to idle.
        if (word_done)       state_nxt = ST_HOLD;
        else if (code_ready) state_nxt = frame_s ? ST_SHIFT : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      clk_prev <= 1'b0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_nxt;
      clk_prev <= clk_s;
      if (in_frame) begin
        if (bit_evt) begin
          shreg   <= shift_nxt;
          bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        end
      end else begin
        // Outside a frame (or frame dropped mid-word) any partial word is lost.
        shreg   <= '0;
        bit_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output word and overrun flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      code    <= '0;
      overrun <= 1'b0;
    end else begin
      if (word_done && !word_drop) begin
        code <= shift_nxt;
      end
      // Set wins over a coincident clear.
      if (word_drop) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_codeword_deserializer.sv
// Testbench for codeword_deserializer: directed frames plus a jittered-phase soak.
// Expected words are queued as frames are sent; a monitor pops on each handshake.
module tb_codeword_deserializer;

  logic       clock;
  logic       reset_n;
  logic       ser_clk;
  logic       ser_data;
  logic       ser_frame;
  logic [6:0] code;
  logic       code_valid;
  logic       code_ready;
  logic       overrun;
  logic       clr_ovr;

  int checks       = 0;
  int errors       = 0;
  int cyc          = 0;
  int valid_cycles = 0;
  int rise_cyc     = 0;
  int edge_cyc     = 0;
  int xfers        = 0;
  int last_xfer    = -100;
  int prev_xfer    = -100;
  logic prev_valid = 1'b0;
  logic [6:0] exp_q[$];

  codeword_deserializer #(.CODE_W(7), .SYNC_STAGES(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ser_clk    (ser_clk),
    .ser_data   (ser_data),
    .ser_frame  (ser_frame),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  // Monitor: samples just after the falling edge, i.e. with the inputs that
  // will be seen at the next rising edge already applied.
  initial begin
    logic [6:0] exp_w;
    forever begin
      @(negedge clock);
      #1;
      if (reset_n !== 1'b1) begin
        prev_valid = 1'b0;
      end else begin
        if (code_valid === 1'b1) begin
          valid_cycles++;
          if (!prev_valid) rise_cyc = cyc;
        end
        prev_valid = (code_valid === 1'b1);
        if (code_valid === 1'b1 && code_ready === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got %h, expected no word", code);
          end else begin
            exp_w = exp_q.pop_front();
            if (code !== exp_w) begin
              errors++;
              $display("FAIL word: got %h, expected %h", code, exp_w);
            end
          end
          prev_xfer = last_xfer;
          last_xfer = cyc;
          xfers++;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d words pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  // Clock-aligned pad driver: pad changes happen on falling edges.
  // rdy_last raises code_ready two cycles after the final ser_clk rise, i.e.
  // exactly on the cycle whose rising edge completes the word.
  task automatic send_bits(input logic [6:0] w, input int nbits,
                           input bit end_frame, input bit rdy_last);
    ser_frame = 1'b1;
    repeat (3) @(negedge clock);
    for (int k = 0; k < nbits; k++) begin
      ser_data = w[k];
      repeat (2) @(negedge clock);
      ser_clk  = 1'b1;
      edge_cyc = cyc;
      repeat (2) @(negedge clock);
      if (rdy_last && k == nbits - 1) code_ready = 1'b1;
      @(negedge clock);
      ser_clk = 1'b0;
      repeat (3) @(negedge clock);
    end
    if (end_frame) begin
      ser_frame = 1'b0;
      repeat (4) @(negedge clock);
    end
  endtask

  // Free-running pad driver with random phase and pulse widths.
  task automatic send_async(input logic [6:0] w);
    ser_frame = 1'b1;
    for (int k = 0; k < 7; k++) begin
      ser_data = w[k];
      #($urandom_range(11, 19));
      ser_clk = 1'b1;
      #($urandom_range(12, 20));
      ser_clk = 1'b0;
      #($urandom_range(12, 20));
    end
    #20;
    ser_frame = 1'b0;
    #($urandom_range(15, 25));
  endtask

  initial begin
    int vc0;
    int x0;
    logic [6:0] w;

    reset_n    = 1'b0;
    ser_clk    = 1'b0;
    ser_data   = 1'b0;
    ser_frame  = 1'b0;
    code_ready = 1'b0;
    clr_ovr    = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    chk("rst_code", 32'(code), 32'h0);
    chk("rst_valid", 32'(code_valid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // Single frame 1,1,0,1,1,0,1 LSB first, ready held high
    code_ready = 1'b1;
    vc0 = valid_cycles;
    exp_q.push_back(7'b1011011);
    send_bits(7'b1011011, 7, 1'b1, 1'b0);
    drain("single");
    chk("single_latency", 32'(rise_cyc - edge_cyc), 32'd3);
    chk("single_valid_cycles", 32'(valid_cycles - vc0), 32'd1);

    // Back-to-back frames with ready low: second word dropped, overrun set
    code_ready = 1'b0;
    exp_q.push_back(7'h5B);
    send_bits(7'h5B, 7, 1'b0, 1'b0);
    send_bits(7'h24, 7, 1'b1, 1'b0);
    repeat (3) @(negedge clock);
    #1;
    chk("ovr_code_held", 32'(code), 32'h5B);
    chk("ovr_valid_held", 32'(code_valid), 32'h1);
    chk("ovr_set", 32'(overrun), 32'h1);
    @(negedge clock);
    clr_ovr = 1'b1;
    @(negedge clock);
    clr_ovr = 1'b0;
    #1;
    chk("ovr_cleared", 32'(overrun), 32'h0);
    code_ready = 1'b1;
    drain("ovr");

    // Aborted frame after 4 bits, then a full 7'h7F
    vc0 = valid_cycles;
    send_bits(7'h0F, 4, 1'b1, 1'b0);
    exp_q.push_back(7'h7F);
    send_bits(7'h7F, 7, 1'b1, 1'b0);
    drain("abort");
    chk("abort_valid_cycles", 32'(valid_cycles - vc0), 32'd1);
    chk("abort_overrun", 32'(overrun), 32'h0);

    // Reset mid-frame after 3 bits; code still holds 7'h7F beforehand
    send_bits(7'h7F, 3, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midrst_code", 32'(code), 32'h0);
    chk("midrst_valid", 32'(code_valid), 32'h0);
    chk("midrst_overrun", 32'(overrun), 32'h0);
    ser_frame = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    vc0 = valid_cycles;
    exp_q.push_back(7'h01);
    send_bits(7'h01, 7, 1'b1, 1'b0);
    drain("midrst");
    chk("midrst_valid_cycles", 32'(valid_cycles - vc0), 32'd1);

    // Word completes on the same cycle the held word is accepted
    code_ready = 1'b0;
    exp_q.push_back(7'h2A);
    send_bits(7'h2A, 7, 1'b1, 1'b0);
    repeat (2) @(negedge clock);
    #1;
    chk("b2b_first_held", 32'(code_valid), 32'h1);
    exp_q.push_back(7'h55);
    send_bits(7'h55, 7, 1'b1, 1'b1);
    drain("b2b");
    chk("b2b_consecutive", 32'(last_xfer - prev_xfer), 32'd1);
    chk("b2b_overrun", 32'(overrun), 32'h0);

    // Random-phase soak
    code_ready = 1'b1;
    x0 = xfers;
    #($urandom_range(0, 9));
    for (int f = 0; f < 1000; f++) begin
      w = 7'($urandom);
      exp_q.push_back(w);
      send_async(w);
    end
    @(negedge clock);
    drain("jitter");
    chk("jitter_word_count", 32'(xfers - x0), 32'd1000);
    chk("jitter_overrun", 32'(overrun), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/codeword_deserializer.md
CODEWORD_DESERIALIZER -- requirements
Module: codeword_deserializer

Interface
REQ-001 Parameter CODE_W, default 7, codeword width delivered to the downstream decoder.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth for asynchronous pin inputs (legal range 2..4).
REQ-003 Port clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port ser_clk  input  1  serial bit clock from pad, asynchronous to clock.
REQ-006 Port ser_data  input  1  serial data from pad, sampled on ser_clk rising edge.
REQ-007 Port ser_frame  input  1  frame enable from pad; high while a codeword is being shifted.
REQ-008 Port code  output  CODE_W  assembled codeword, feeds decoder io_in.
REQ-009 Port code_valid  output  1  code holds a complete, unconsumed word.
REQ-010 Port code_ready  input  1  downstream accepts code this cycle.
REQ-011 Port overrun  output  1  sticky: a complete word was dropped.
REQ-012 Port clr_ovr  input  1  synchronous clear of overrun.

Function
REQ-013 ser_clk, ser_data and ser_frame each pass through SYNC_STAGES flops; only synchronized versions are used.
REQ-014 Bit event = synchronized ser_clk high while its previous-cycle value is low; one event per pad rising edge.
REQ-015 Bits arrive LSB first; bit k of a frame lands in code[k].
REQ-016 States: IDLE (no frame), SHIFT (collecting), HOLD (word presented, awaiting ready).
REQ-017 IDLE -> SHIFT when synchronized ser_frame is high; bit counter = 0, shifter cleared.
REQ-018 In SHIFT, each bit event shifts the synchronized ser_data in and increments the counter (range 0..CODE_W-1).
REQ-019 On the bit event completing bit CODE_W-1, code loads the full word and code_valid rises at the same edge; state -> HOLD; counter wraps to 0.
REQ-020 Pad-edge to code_valid latency: SYNC_STAGES+1 clock cycles (3 at default).
REQ-021 ser_frame falling in SHIFT before CODE_W bits: partial word discarded, no code_valid, state -> IDLE; overrun unaffected.
REQ-022 Handshake: transfer occurs on a cycle with code_valid and code_ready both high; code_valid drops at that edge unless a new word completes at the same edge.
REQ-023 code stays stable while code_valid is high and code_ready is low.
REQ-024 In HOLD, shifting of the next frame continues; a second word completing while code_valid is high and code_ready is low is dropped, code unchanged, overrun set.
REQ-025 Word completing on the same cycle as a transfer: new word loads, code_valid stays high, no overrun.
REQ-026 clr_ovr clears overrun; if clr_ovr and a new overrun coincide, overrun is set (set wins).
REQ-027 code_valid does not depend combinationally on code_ready.

Reset
REQ-028 reset_n low asynchronously forces: synchronizers 0, state IDLE, counter 0, code all-zero, code_valid 0, overrun 0.
REQ-029 Reset mid-frame discards the partial word; after release, a fresh ser_frame rise is needed before shifting.
REQ-030 Deassertion takes effect at the next clock edge; no bit event is generated by the first post-reset sample.

Structure
REQ-031 Shared package holds CODE_W default, state enum (IDLE, SHIFT, HOLD) and counter width constant clog2(CODE_W).
REQ-032 One sub-module, pin_sync (parameterized depth, 1-bit), instantiated three times.

Verification
REQ-033 Frame 1,1,0,1,1,0,1 (LSB first) with code_ready=1 -> code=7'b1011011, code_valid high for exactly one cycle, 3 cycles after 7th pad edge.
REQ-034 Two back-to-back frames 7'h5B, 7'h24 with code_ready=0 -> code stays 7'h5B, overrun=1 after second word; clr_ovr pulse -> overrun=0.
REQ-035 ser_frame dropped after 4 bits, then full frame 7'h7F -> only 7'h7F presented, overrun=0.
REQ-036 reset_n pulsed low after 3 bits of a frame -> all outputs 0 immediately; next full frame 7'h01 delivered correctly.
REQ-037 Word completes on the same cycle code_ready accepts previous -> both words delivered in order, code_valid never low between them, overrun=0.
REQ-038 ser_clk edge jittered relative to clock (random phase, 1000 frames) -> every word matches sent value, no duplicate bit events.
